mem_line_arbiter: RTL and testbench
===================================

# mem_line_arbiter

Two-requester arbiter that shares the single 128-bit line port of the backing memory between the instruction-side and data-side caches. It sits between the two cache instances' memory-side ports and the memory controller. It grants one line transaction at a time, with round-robin fairness, and holds the grant until the memory completes. It registers the granted request onto the memory port, routes the completion back to the owner, and flags memory stalls that run past a programmable limit.

## Interface
- ADDR_W, 17, line-request address width (matches the cache memory port)
- LINE_W, 128, line data width
- TIMEOUT, 1024, cycles in BUSY before `timeout_err` sets; 0 disables the watchdog
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- i_req_addr  in  ADDR_W  instruction-side line address
- i_req_valid  in  1  instruction-side request pending
- i_req_wr  in  1  1 = write line, 0 = read line
- i_wr_data  in  LINE_W  instruction-side write line
- i_rd_data  out  LINE_W  read line; equals `mem_rd_data` at all times
- i_req_ready  out  1  one-cycle completion pulse to the instruction side
- d_req_addr, d_req_valid, d_req_wr, d_wr_data, d_rd_data, d_req_ready: same as the `i_*` ports, for the data side
- mem_req_addr  out  ADDR_W  granted address (registered)
- mem_req_valid  out  1  request to memory (registered)
- mem_req_wr  out  1  granted direction (registered)
- mem_wr_data  out  LINE_W  granted write line (registered)
- mem_rd_data  in  LINE_W  memory read line, valid while `mem_req_ready` is high
- mem_req_ready  in  1  memory completion, one cycle
- busy  out  1  1 while in BUSY
- grant_d  out  1  owner of the current or last grant (0 = I, 1 = D)
- timeout_err  out  1  sticky watchdog flag

## Operation
- States: IDLE, BUSY.
- IDLE, no valid requester: stay in IDLE.
- IDLE, exactly one valid requester: grant it.
- IDLE, both valid: grant the side that did not own the previous grant (round-robin).
- On grant:
  - latch that side's addr, wr and wr_data into the `mem_*` registers;
  - set `mem_req_valid`, `grant_d` and the last-owner record;
  - go to BUSY.
- BUSY:
  - hold all `mem_*` outputs stable;
  - ignore both `*_req_valid` inputs;
  - increment the watchdog counter.
- BUSY with `mem_req_ready` = 1:
  - drive the owner's `*_req_ready` high combinationally in the same cycle;
  - clear `mem_req_valid` at the next edge;
  - clear the watchdog counter;
  - return to IDLE.
- The non-owner's ready never asserts.
- `mem_req_ready` outside BUSY is ignored, including a level held high continuously.
- Requester contract: hold addr, wr and data stable from valid until ready. A requester that drops valid mid-transaction is a protocol violation. The latched transaction still completes and the ready pulse still goes to that side.
- A requester that keeps valid high after its ready pulse is treated as issuing a new request in the following IDLE cycle.
- Watchdog:
  - fires when the counter reaches TIMEOUT while in BUSY;
  - sets `timeout_err` (stays set until reset);
  - the transaction keeps waiting; there is no abort.
  - The counter saturates at TIMEOUT.

## Timing
- Reset (async assert, sync to clk on deassert):
  - state goes to IDLE;
  - `mem_req_valid`, `mem_req_wr`, `mem_req_addr`, `mem_wr_data` go to 0;
  - both `*_req_ready` go to 0, `busy` to 0, `timeout_err` to 0;
  - `grant_d` goes to 1, so the first simultaneous request goes to I.
- Reset mid-BUSY drops the transaction. Requesters re-issue after reset.
- Request latency: valid sampled in IDLE at cycle N puts `mem_req_valid` = 1 from cycle N+1.
- Response latency: 0. `*_req_ready` and `*_rd_data` coincide with `mem_req_ready`.
- `mem_req_valid` is low for at least one cycle between transactions. Peak throughput is one line per 2 cycles, reached when memory answers in the first BUSY cycle.
- Worst-case wait for a requester: one full transaction of the other side, plus one cycle.

## Test plan
- Single I read:
  - stimulus: `i_req_valid` = 1, `i_req_addr` = 17'hFADE, wr = 0;
  - memory answers 3 cycles after `mem_req_valid` with `mem_rd_data` = {4{32'hDEADBEEF}};
  - required: `mem_req_addr` = 17'hFADE one cycle after valid; `i_req_ready` pulses for exactly one cycle with `i_rd_data` = {4{32'hDEADBEEF}}; `d_req_ready` stays 0.
- Simultaneous requests after reset:
  - stimulus: I reads 17'h0100 and D writes 17'hDAFE with {4{32'hFEEDDEAD}}, both held valid;
  - required: I is granted first; D's `mem_req_wr` = 1 and `mem_wr_data` = {4{32'hFEEDDEAD}} appear exactly 2 cycles after I's ready pulse.
- Fairness:
  - stimulus: both sides keep valid high for 6 transactions with zero-wait memory;
  - required: grant order is I, D, I, D, I, D and `mem_req_valid` toggles 1, 0, 1, 0, …
- Stray ready:
  - stimulus: `mem_req_ready` held at 1 with no requests for 10 cycles, then a D read;
  - required: no ready pulses before the D grant; D completes in the first BUSY cycle.
- Reset mid-transaction:
  - stimulus: `rst_n` pulled low during BUSY;
  - required: `mem_req_valid` = 0 and `busy` = 0 immediately, with no ready pulse; after release, a new I request is granted normally.
- Watchdog:
  - stimulus: TIMEOUT = 8, memory never answers;
  - required: `timeout_err` rises after 8 BUSY cycles and stays high when memory later answers; only a reset clears it.

Source files
------------

// File: rtl/mem_line_arbiter.sv
// mem_line_arbiter
//   Shares the single line-wide memory port between the instruction-side
//   and data-side caches. One line transaction at a time, round-robin
//   between the two sides, grant held until memory completes.
//
// Ports
//   clk, rst_n                       clock (rising edge), async active-low reset
//   i_req_* / i_wr_data / i_rd_data  instruction-side line port
//   d_req_* / d_wr_data / d_rd_data  data-side line port
//   i_req_ready / d_req_ready        one-cycle completion pulse to the owner
//   mem_req_* / mem_wr_data          registered request to memory
//   mem_rd_data / mem_req_ready      memory read line and completion
//   busy                             transaction outstanding
//   grant_d                          owner of current/last grant (1 = D)
//   timeout_err                      sticky watchdog flag
module mem_line_arbiter #(
  parameter int ADDR_W  = 17,
  parameter int LINE_W  = 128,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic              i_req_valid,
  input  logic              i_req_wr,
  input  logic [LINE_W-1:0] i_wr_data,
  output logic [LINE_W-1:0] i_rd_data,
  output logic              i_req_ready,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic              d_req_valid,
  input  logic              d_req_wr,
  input  logic [LINE_W-1:0] d_wr_data,
  output logic [LINE_W-1:0] d_rd_data,
  output logic              d_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_req_valid,
  output logic              mem_req_wr,
  output logic [LINE_W-1:0] mem_wr_data,
  input  logic [LINE_W-1:0] mem_rd_data,
  input  logic              mem_req_ready,
  output logic              busy,
  output logic              grant_d,
  output logic              timeout_err
);

  typedef enum logic {IDLE, BUSY} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              wr;
    logic [LINE_W-1:0] data;
  } line_req_t;

  // Wide enough to hold TIMEOUT itself; +2 keeps TIMEOUT = 0 legal.
  localparam int                CNT_W = $clog2(TIMEOUT + 2);
  localparam logic [CNT_W-1:0]  LIMIT = CNT_W'(TIMEOUT);

  state_t     state, state_nxt;
  line_req_t  i_req, d_req, mem_q;
  logic       take, take_d, done;
  logic [CNT_W-1:0] wd_cnt, wd_inc;

  assign i_req = '{addr: i_req_addr, wr: i_req_wr, data: i_wr_data};
  assign d_req = '{addr: d_req_addr, wr: d_req_wr, data: d_wr_data};

  // Next state and grant decision. Request inputs are only looked at in
  // IDLE; in BUSY only the memory completion matters.
  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    take_d    = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        take   = i_req_valid | d_req_valid;
        // On a tie, the side that did not own the last grant wins.
        take_d = d_req_valid & (~i_req_valid | ~grant_d);
        if (take) state_nxt = BUSY;
      end
      BUSY: begin
        done = mem_req_ready;
        if (done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Granted request register; held stable for the whole BUSY period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q         <= '0;
      mem_req_valid <= 1'b0;
      grant_d       <= 1'b1;   // first tie after reset goes to I
    end else if (take) begin
      mem_q         <= take_d ? d_req : i_req;
      mem_req_valid <= 1'b1;
      grant_d       <= take_d;
    end else if (done) begin
      mem_req_valid <= 1'b0;
    end
  end

  assign wd_inc = wd_cnt + 1'b1;

  // Watchdog: counts BUSY cycles without completion, saturating at LIMIT.
  // The error flag is sticky; the transaction is never aborted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else if (state != BUSY || mem_req_ready) begin
      wd_cnt <= '0;
    end else if (TIMEOUT != 0 && wd_cnt != LIMIT) begin
      wd_cnt <= wd_inc;
      if (wd_inc == LIMIT) timeout_err <= 1'b1;
    end
  end

  assign busy         = (state == BUSY);
  assign i_req_ready  = done & ~grant_d;
  assign d_req_ready  = done &  grant_d;
  assign i_rd_data    = mem_rd_data;
  assign d_rd_data    = mem_rd_data;
  assign mem_req_addr = mem_q.addr;
  assign mem_req_wr   = mem_q.wr;
  assign mem_wr_data  = mem_q.data;

endmodule

// File: tb/tb_mem_line_arbiter.sv
// Directed bench for mem_line_arbiter (watchdog limit set to 8).
// Inputs are driven on the falling edge; outputs are checked 1 ns later,
// i.e. they describe the cycle before the next rising edge.
module tb_mem_line_arbiter;
  localparam int AW = 17;
  localparam int LW = 128;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] i_req_addr, d_req_addr, mem_req_addr;
  logic          i_req_valid, i_req_wr, d_req_valid, d_req_wr;
  logic [LW-1:0] i_wr_data, d_wr_data, i_rd_data, d_rd_data;
  logic          i_req_ready, d_req_ready;
  logic          mem_req_valid, mem_req_wr, mem_req_ready;
  logic [LW-1:0] mem_wr_data, mem_rd_data;
  logic          busy, grant_d, timeout_err;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_line_arbiter #(.ADDR_W(AW), .LINE_W(LW), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_addr(i_req_addr), .i_req_valid(i_req_valid), .i_req_wr(i_req_wr),
    .i_wr_data(i_wr_data), .i_rd_data(i_rd_data), .i_req_ready(i_req_ready),
    .d_req_addr(d_req_addr), .d_req_valid(d_req_valid), .d_req_wr(d_req_wr),
    .d_wr_data(d_wr_data), .d_rd_data(d_rd_data), .d_req_ready(d_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_valid(mem_req_valid),
    .mem_req_wr(mem_req_wr), .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data), .mem_req_ready(mem_req_ready),
    .busy(busy), .grant_d(grant_d), .timeout_err(timeout_err)
  );

  task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    i_req_valid = 1'b0; i_req_wr = 1'b0; i_req_addr = '0; i_wr_data = '0;
    d_req_valid = 1'b0; d_req_wr = 1'b0; d_req_addr = '0; d_wr_data = '0;
    mem_req_ready = 1'b0; mem_rd_data = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One cycle of the fairness run: inputs and the outputs expected in it.
  typedef struct {
    logic          iv, dv, mr;
    logic          mv, gd, ir, dr, wr;
    logic [AW-1:0] addr;
  } vec_t;

  vec_t tbl[13];

  localparam logic [LW-1:0] I_DATA = {4{32'h11112222}};
  localparam logic [LW-1:0] D_DATA = {4{32'hFEEDDEAD}};

  initial begin
    logic [LW-1:0] rd;

    //          iv    dv    mr    mv    gd    ir    dr    wr    addr
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 17'h00000};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 17'h00100};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 17'h00100};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 17'h0DAFE};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 17'h0DAFE};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 17'h00100};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 17'h00100};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 17'h0DAFE};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 17'h0DAFE};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 17'h00100};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 17'h00100};
    tbl[11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 17'h0DAFE};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 17'h0DAFE};

    idle_inputs();
    apply_reset();

    // Reset state
    #1;
    chk("rst mem_req_valid", mem_req_valid, 1'b0);
    chk("rst mem_req_addr",  mem_req_addr,  '0);
    chk("rst mem_req_wr",    mem_req_wr,    1'b0);
    chk("rst mem_wr_data",   mem_wr_data,   '0);
    chk("rst busy",          busy,          1'b0);
    chk("rst grant_d",       grant_d,       1'b1);
    chk("rst timeout_err",   timeout_err,   1'b0);
    chk("rst i_req_ready",   i_req_ready,   1'b0);
    chk("rst d_req_ready",   d_req_ready,   1'b0);

    // Simultaneous requests + fairness with zero-wait memory; mem_req_ready
    // held high also exercises that it is ignored in IDLE.
    i_req_addr = 17'h00100; i_req_wr = 1'b0; i_wr_data = I_DATA;
    d_req_addr = 17'h0DAFE; d_req_wr = 1'b1; d_wr_data = D_DATA;
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      i_req_valid   = tbl[k].iv;
      d_req_valid   = tbl[k].dv;
      mem_req_ready = tbl[k].mr;
      rd            = {4{32'hC0DE0000 + 32'(k)}};
      mem_rd_data   = rd;
      #1;
      chk($sformatf("v%0d mem_req_valid", k), mem_req_valid, tbl[k].mv);
      chk($sformatf("v%0d grant_d", k),       grant_d,       tbl[k].gd);
      chk($sformatf("v%0d i_req_ready", k),   i_req_ready,   tbl[k].ir);
      chk($sformatf("v%0d d_req_ready", k),   d_req_ready,   tbl[k].dr);
      chk($sformatf("v%0d mem_req_wr", k),    mem_req_wr,    tbl[k].wr);
      chk($sformatf("v%0d mem_req_addr", k),  mem_req_addr,  tbl[k].addr);
      chk($sformatf("v%0d busy", k),          busy,          tbl[k].mv);
      if (tbl[k].mv)
        chk($sformatf("v%0d mem_wr_data", k), mem_wr_data, tbl[k].gd ? D_DATA : I_DATA);
      if (tbl[k].ir) chk($sformatf("v%0d i_rd_data", k), i_rd_data, rd);
      if (tbl[k].dr) chk($sformatf("v%0d d_rd_data", k), d_rd_data, rd);
    end
    idle_inputs();

    // Single I read, memory answers 3 cycles after mem_req_valid
    @(negedge clk);
    i_req_valid = 1'b1; i_req_addr = 17'h0FADE; i_req_wr = 1'b0;
    #1 chk("single pre-grant valid", mem_req_valid, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      chk($sformatf("single wait%0d valid", k), mem_req_valid, 1'b1);
      chk($sformatf("single wait%0d addr", k),  mem_req_addr,  17'h0FADE);
      chk($sformatf("single wait%0d i_ready", k), i_req_ready, 1'b0);
      chk($sformatf("single wait%0d d_ready", k), d_req_ready, 1'b0);
    end
    @(negedge clk);
    mem_req_ready = 1'b1; mem_rd_data = {4{32'hDEADBEEF}};
    #1;
    chk("single i_ready",  i_req_ready, 1'b1);
    chk("single d_ready",  d_req_ready, 1'b0);
    chk("single i_rd_data", i_rd_data, {4{32'hDEADBEEF}});
    @(negedge clk);
    i_req_valid = 1'b0; mem_req_ready = 1'b0;
    #1;
    chk("single ready width", i_req_ready, 1'b0);
    chk("single valid drop",  mem_req_valid, 1'b0);
    chk("single busy drop",   busy, 1'b0);

    // Stray mem_req_ready while idle, then a D read
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      mem_req_ready = 1'b1; mem_rd_data = {4{32'h5A5A5A5A}};
      #1;
      chk($sformatf("stray%0d i_ready", k), i_req_ready, 1'b0);
      chk($sformatf("stray%0d d_ready", k), d_req_ready, 1'b0);
      chk($sformatf("stray%0d busy", k),    busy, 1'b0);
    end
    @(negedge clk);
    d_req_valid = 1'b1; d_req_addr = 17'h01234; d_req_wr = 1'b0;
    #1 chk("stray pre-grant d_ready", d_req_ready, 1'b0);
    @(negedge clk); #1;
    chk("stray busy",      busy, 1'b1);
    chk("stray grant_d",   grant_d, 1'b1);
    chk("stray addr",      mem_req_addr, 17'h01234);
    chk("stray d_ready",   d_req_ready, 1'b1);
    chk("stray i_ready",   i_req_ready, 1'b0);
    chk("stray d_rd_data", d_rd_data, {4{32'h5A5A5A5A}});
    @(negedge clk);
    d_req_valid = 1'b0; mem_req_ready = 1'b0;
    #1 chk("stray done busy", busy, 1'b0);

    // Reset in the middle of a transaction
    @(negedge clk);
    i_req_valid = 1'b1; i_req_addr = 17'h00AAA; i_req_wr = 1'b0;
    @(negedge clk);
    #1 chk("midrst busy before", busy, 1'b1);
    rst_n = 1'b0; mem_req_ready = 1'b1;
    #1;
    chk("midrst valid",   mem_req_valid, 1'b0);
    chk("midrst busy",    busy, 1'b0);
    chk("midrst i_ready", i_req_ready, 1'b0);
    chk("midrst d_ready", d_req_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1; mem_req_ready = 1'b0;
    @(negedge clk); #1;
    chk("midrst regrant valid", mem_req_valid, 1'b1);
    chk("midrst regrant addr",  mem_req_addr, 17'h00AAA);
    chk("midrst regrant owner", grant_d, 1'b0);
    mem_req_ready = 1'b1;
    #1 chk("midrst i_ready", i_req_ready, 1'b1);
    @(negedge clk);
    i_req_valid = 1'b0; mem_req_ready = 1'b0;

    // Watchdog: memory stalls; flag sets after 8 BUSY cycles and is sticky
    @(negedge clk);
    d_req_valid = 1'b1; d_req_addr = 17'h00BAD; d_req_wr = 1'b1; d_wr_data = D_DATA;
    @(negedge clk);
    for (int k = 1; k <= 7; k++) @(negedge clk);
    #1 chk("wd at 7 cycles", timeout_err, 1'b0);
    @(negedge clk);
    #1 chk("wd at 8 cycles", timeout_err, 1'b1);
    repeat (5) @(negedge clk);
    #1;
    chk("wd still busy",  busy, 1'b1);
    chk("wd held",        timeout_err, 1'b1);
    chk("wd wr held",     mem_wr_data, D_DATA);
    mem_req_ready = 1'b1;
    #1 chk("wd late d_ready", d_req_ready, 1'b1);
    @(negedge clk);
    d_req_valid = 1'b0; mem_req_ready = 1'b0;
    #1;
    chk("wd sticky idle", timeout_err, 1'b1);
    chk("wd idle busy",   busy, 1'b0);
    apply_reset();
    #1 chk("wd cleared by reset", timeout_err, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
